timer_arbiter: RTL
==================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the delay counter.
REQ-002 Parameter: CW, 32, counter and duration width in bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  NREQ  per-requester delay request, level-sensitive.
REQ-006 Port: req_dur  input  NREQ*CW  packed durations; requester i uses bits [i*CW +: CW].
REQ-007 Port: gnt  output  NREQ  one-hot owner of the shared counter; all-zero when unowned.
REQ-008 Port: done  output  NREQ  one-cycle completion pulse to the owner.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: owner_cnt  output  CW  current counter value, for debug.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE; all outputs are registered.
REQ-012 IDLE: on an edge where req is non-zero, the block SHALL grant exactly one requester, latch its req_dur into dur_q, clear the count to 0, set gnt one-hot and go to RUN.
REQ-013 Arbitration SHALL be round-robin: search starts at index (last_granted+1) mod NREQ, and last_granted updates at each grant.
REQ-014 RUN, owner req high, count != dur_q: count SHALL increment by 1 per edge.
REQ-015 RUN, owner req high, count == dur_q: the block SHALL go to DONE and assert done[owner] for exactly that next cycle; count holds.
REQ-016 DONE: on the next edge, done and gnt SHALL clear, state SHALL return to IDLE, and no grant is made at this edge.
REQ-017 Latency: with dur_q = D, done SHALL rise D+1 cycles after gnt rises; D = 0 gives done one cycle after gnt.
REQ-018 Abort: a RUN edge sampling req[owner] low SHALL return to IDLE, clear gnt, and never pulse done; abort takes priority over the REQ-015 compare.
REQ-019 req_dur changes after the grant SHALL be ignored; only dur_q is compared.
REQ-020 Requests from non-owners during RUN or DONE SHALL be held pending (level), with no effect until IDLE.
REQ-021 Count and compare SHALL use CW-bit unsigned arithmetic; the count never wraps because it stops at dur_q, and dur_q = 2^CW-1 is legal.
REQ-022 At most one done bit SHALL be high in any cycle, and only the bit matching the gnt bit.
REQ-023 busy SHALL be high in RUN and DONE and low in IDLE.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, gnt=0, done=0, busy=0, count=0, dur_q=0 and last_granted=NREQ-1, so requester 0 wins first.
REQ-025 Reset asserted mid-RUN SHALL discard the in-progress delay with no done pulse; after release, arbitration restarts per REQ-024.
REQ-026 Release of rst_n SHALL be synchronised by the integrator; the block takes no action on the release edge beyond normal IDLE sampling.

Verification
REQ-027 Single request: req=0001, dur0=3 -> gnt=0001 next cycle; done[0] pulses 4 cycles after gnt rises; gnt clears the cycle after done.
REQ-028 Zero duration: req=0010, dur1=0 -> done[1] pulses one cycle after gnt=0010.
REQ-029 Round-robin: req=1111 held, all durations 1 -> grant order 0,1,2,3,0; each done appears only on the owner's bit.
REQ-030 Abort: req=0100, dur2=10; drop req[2] at count=4 -> gnt clears next edge, done stays 0, busy low.
REQ-031 Latch check: req=0001, dur0=5; change dur0 to 1 during RUN -> done still at count 5, i.e. 6 cycles after gnt.
REQ-032 Reset mid-RUN: rst_n low at count=2 -> gnt, done, busy and owner_cnt are 0 immediately; after release, req=1000 -> gnt=1000.

Source files
------------

// File: rtl/timer_arbiter.sv
// Shared delay counter granted round-robin to NREQ requesters; the owner gets a
// one-cycle done pulse once its latched duration has elapsed.
module timer_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_dur,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CW-1:0]        owner_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   dur_q, dur_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   own_q, own_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        last_d  = last_q;
        own_d   = own_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StRun;
                    own_d   = pick;
                    last_d  = pick;
                    dur_d   = req_dur[pick*CW +: CW];
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                // Abort wins over the compare.
                if (!req[own_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == dur_q) begin
                    state_d = StDone;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            dur_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
            own_q   <= own_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign owner_cnt = cnt_q;

endmodule
